task_4_sweep_ctrl: RTL and testbench
====================================

# task_4_sweep_ctrl

Exhaustive-sweep controller for the 5-input combinational `task_4` function block. On `start` it drives all 32 input vectors in ascending order onto the block's inputs. It holds each vector for a programmable settle time, samples `Z`, and assembles the 32-bit truth table. Optionally it checks the result against a golden table. It sits beside a `task_4` instance and replaces hand-written vector sequences as the lab's self-test sequencer.

## Interface
- `SETTLE`, default 2: cycles each vector is held before `Z` is sampled; legal range 1–15.
- `GOLDEN`, default 32'h0000_0000: expected truth table, bit i = expected `Z` for vector i. Used only with the compare feature.

- `clk` input 1: single clock, rising-edge.
- `rst_n` input 1: asynchronous active-low reset.
- `start` input 1: one-cycle request to begin a sweep; honoured only in IDLE.
- `abort` input 1: synchronous sweep cancel.
- `z_in` input 1: `Z` output of the `task_4` instance.
- `x_out` output 5: vector to `task_4`; `x_out[4]`=x1 … `x_out[0]`=x5.
- `busy` output 1: high while sweeping.
- `done` output 1: one-cycle pulse on sweep completion.
- `truth` output 32: captured truth table; bit i = sampled `Z` for vector i.
- `pass` output 1: compare result of the last completed sweep.
- `err_cnt` output 6: mismatch count, 0–32.
- `first_err` output 5: index of the first mismatching vector.

## Operation
- States: IDLE, HOLD, FIN.
- Reset (async, `rst_n`=0): state IDLE. All outputs 0: `x_out`, `busy`, `done`, `truth`, `pass`, `err_cnt`, `first_err`. Settle counter is 0.
- IDLE with `start`=1:
  - Go to HOLD.
  - Set `x_out`=0, settle counter=0, `busy`=1.
  - Clear `truth`, `err_cnt`, `first_err`, `pass`.
- HOLD, counter < `SETTLE`-1: increment the counter; `x_out` is unchanged.
- HOLD, counter = `SETTLE`-1 (the sample edge):
  - Write `truth[x_out]` ← `z_in`.
  - If `x_out`=31, go to FIN; otherwise increment `x_out` and reset the counter to 0.
- FIN: lasts one cycle with `done`=1 and `busy`=0, then returns to IDLE. `x_out` holds 31 until the next start.
- `start` in HOLD or FIN is ignored. No queuing.
- `abort`=1 in HOLD:
  - Next state is IDLE and `busy`=0.
  - No `done` pulse is issued.
  - `truth` keeps the partial result and `x_out` holds its value.
  - `abort` has priority over the sample edge.
- `abort` in IDLE or FIN has no effect.
- Reset mid-sweep: immediate return to IDLE with all outputs zeroed.

## Timing
- `start` is sampled at edge E0. `busy` rises after E0 and `x_out`=0 is valid in the following cycle.
- Each vector is held for exactly `SETTLE` cycles. Sampling happens on the last edge of that window, so `z_in` is given `SETTLE` cycles to settle.
- The sweep occupies 32×`SETTLE` cycles of `busy`, followed by 1 `done` cycle.
- `truth`, `pass`, `err_cnt` and `first_err` are final and stable when `done` is high. They hold until the next accepted `start`.
- `z_in` is treated as synchronous to `clk`. No synchronizer is included.

## Configuration
- Macro `SWEEP_COMPARE_EN`.
- Defined:
  - On every sample edge, `z_in` is compared with `GOLDEN[x_out]`.
  - Each mismatch increments `err_cnt`.
  - The first mismatch loads `first_err` with `x_out`.
  - On entry to FIN, `pass` ← (final `err_cnt` == 0).
- Undefined:
  - No compare logic is built.
  - `pass`, `err_cnt` and `first_err` are tied to 0.
  - `GOLDEN` is unused.
  - `truth` capture is unchanged.

## Test plan
- Full sweep: model `z_in` as the XOR of the `x_out` bits, `SETTLE`=2, pulse `start`.
  - `busy` stays high for 64 cycles, then `done` pulses once.
  - `truth`=32'h9669_6996.
- Compare pass (macro on): same stimulus with `GOLDEN`=32'h9669_6996.
  - `pass`=1, `err_cnt`=0, `first_err`=0.
- Compare fail (macro on): `GOLDEN`=32'h9669_6994.
  - `pass`=0, `err_cnt`=1, `first_err`=1.
- Abort: assert `abort` while `x_out`=10.
  - `busy` drops on the next cycle, with no `done` pulse.
  - `truth[31:10]`=0.
  - A new `start` restarts from `x_out`=0.
- Ignored start and reset:
  - A `start` pulse mid-sweep is ignored and the total cycle count is unchanged.
  - `rst_n` low mid-sweep zeros all outputs asynchronously and the block returns to IDLE.
- `SETTLE`=1: `busy` lasts 32 cycles and the `truth` result matches the parity scenario.

Source files
------------

// File: rtl/task_4_sweep_ctrl.sv
// Exhaustive-sweep sequencer for the 5-input task_4 block: walks all 32 vectors,
// samples Z after SETTLE cycles each and builds the truth table. Optional golden compare: SWEEP_COMPARE_EN.
module task_4_sweep_ctrl #(
   parameter int unsigned SETTLE = 2,
   parameter logic [31:0] GOLDEN = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        abort,
   input  logic        z_in,
   output logic [4:0]  x_out,
   output logic        busy,
   output logic        done,
   output logic [31:0] truth,
   output logic        pass,
   output logic [5:0]  err_cnt,
   output logic [4:0]  first_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      FIN  = 2'd2
   } state_t;

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 32'd1);

   state_t     state_r;
   logic [3:0] cnt_r;
   logic       sample_s;

   assign sample_s = (cnt_r == SETTLE_LAST);

`ifdef SWEEP_COMPARE_EN
   logic       mismatch_s;
   logic [5:0] err_next_s;

   // Mismatch of the current sample against the golden table, and the count it produces
   always_comb begin
      mismatch_s = z_in ^ GOLDEN[x_out];
      err_next_s = err_cnt + {5'd0, mismatch_s};
   end
`endif

   // Sweep FSM with all outputs registered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         cnt_r     <= 4'd0;
         x_out     <= 5'd0;
         busy      <= 1'b0;
         done      <= 1'b0;
         truth     <= 32'd0;
`ifdef SWEEP_COMPARE_EN
         pass      <= 1'b0;
         err_cnt   <= 6'd0;
         first_err <= 5'd0;
`endif
      end else begin
         done <= 1'b0;
         case (state_r)
            IDLE: begin
               if (start) begin
                  state_r   <= HOLD;
                  cnt_r     <= 4'd0;
                  x_out     <= 5'd0;
                  busy      <= 1'b1;
                  truth     <= 32'd0;
`ifdef SWEEP_COMPARE_EN
                  pass      <= 1'b0;
                  err_cnt   <= 6'd0;
                  first_err <= 5'd0;
`endif
               end else begin
                  state_r <= IDLE;
               end
            end
            HOLD: begin
               // abort wins over a coinciding sample edge; partial table is kept
               if (abort) begin
                  state_r <= IDLE;
                  busy    <= 1'b0;
               end else if (sample_s) begin
                  truth[x_out] <= z_in;
`ifdef SWEEP_COMPARE_EN
                  err_cnt <= err_next_s;
                  if (mismatch_s && (err_cnt == 6'd0)) begin
                     first_err <= x_out;
                  end else begin
                     first_err <= first_err;
                  end
`endif
                  if (x_out == 5'd31) begin
                     state_r <= FIN;
                     busy    <= 1'b0;
                     done    <= 1'b1;
`ifdef SWEEP_COMPARE_EN
                     pass    <= (err_next_s == 6'd0);
`endif
                  end else begin
                     x_out <= x_out + 5'd1;
                     cnt_r <= 4'd0;
                  end
               end else begin
                  cnt_r <= cnt_r + 4'd1;
               end
            end
            FIN: begin
               state_r <= IDLE;
            end
            default: begin
               state_r <= IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

`ifndef SWEEP_COMPARE_EN
   // Compare results are constant zero; GOLDEN folds away
   assign pass      = 1'b0 & (^GOLDEN);
   assign err_cnt   = 6'd0;
   assign first_err = 5'd0;
`endif

endmodule

// File: tb/tb_task_4_sweep_ctrl.sv
// Directed bench for task_4_sweep_ctrl with a parity stand-in for task_4 and a truth-table scoreboard.
module tb_task_4_sweep_ctrl;

   localparam logic [31:0] PARITY_TT = 32'h9669_6996;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start0, start1, abort0, abort1;
   logic        z0, z1;
   logic [4:0]  x0, x1, fe0, fe1;
   logic        busy0, busy1, done0, done1, pass0, pass1;
   logic [31:0] truth0, truth1;
   logic [5:0]  ec0, ec1;

   typedef struct {
      logic [31:0] truth;
      int          busy_cycles;
      int          dones;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   assign z0 = ^x0;
   assign z1 = ^x1;

   task_4_sweep_ctrl #(.SETTLE(2), .GOLDEN(32'h9669_6996)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .z_in(z0),
      .x_out(x0), .busy(busy0), .done(done0), .truth(truth0), .pass(pass0),
      .err_cnt(ec0), .first_err(fe0)
   );

   task_4_sweep_ctrl #(.SETTLE(1), .GOLDEN(32'h9669_6994)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .z_in(z1),
      .x_out(x1), .busy(busy1), .done(done1), .truth(truth1), .pass(pass1),
      .err_cnt(ec1), .first_err(fe1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic drive(input int sel, input logic st, input logic ab);
      if (sel == 0) begin
         start0 = st;
         abort0 = ab;
      end else begin
         start1 = st;
         abort1 = ab;
      end
   endtask

   function automatic logic get_busy(input int sel);
      return (sel == 0) ? busy0 : busy1;
   endfunction

   function automatic logic get_done(input int sel);
      return (sel == 0) ? done0 : done1;
   endfunction

   function automatic logic [4:0] get_x(input int sel);
      return (sel == 0) ? x0 : x1;
   endfunction

   function automatic logic [31:0] get_truth(input int sel);
      return (sel == 0) ? truth0 : truth1;
   endfunction

   // One sweep: push expectation, pulse start, monitor busy/done, pop and compare.
   task automatic run(input int sel, input logic [31:0] exp_truth, input int exp_busy,
                      input int inject_start, input int abort_x, input string tag);
      exp_t e;
      int   busy_cnt = 0;
      int   done_cnt = 0;
      int   post     = 0;
      int   abort_cyc = -1;
      bit   aborted  = 0;
      e.truth       = exp_truth;
      e.busy_cycles = exp_busy;
      e.dones       = (abort_x >= 0) ? 0 : 1;
      sb.push_back(e);
      @(posedge clk); #1 drive(sel, 1'b1, 1'b0);
      @(posedge clk); #1 drive(sel, 1'b0, 1'b0);
      @(negedge clk);
      check({tag, "_x_start"}, 32'(get_x(sel)), 32'd0);
      for (int cyc = 0; cyc < 400; cyc++) begin
         if (get_busy(sel)) busy_cnt++;
         if (get_done(sel)) done_cnt++;
         if (aborted && (cyc == abort_cyc + 1)) begin
            check({tag, "_busy_drop"}, 32'(get_busy(sel)), 32'd0);
            check({tag, "_x_hold"}, 32'(get_x(sel)), 32'(abort_x));
         end
         if ((abort_x >= 0) && !aborted && get_busy(sel) && (get_x(sel) == 5'(abort_x))) begin
            aborted   = 1;
            abort_cyc = cyc;
            drive(sel, 1'b0, 1'b1);
         end else begin
            drive(sel, (cyc == inject_start), 1'b0);
         end
         if ((done_cnt > 0) || aborted) post++;
         if (post >= 4) break;
         @(negedge clk);
      end
      drive(sel, 1'b0, 1'b0);
      e = sb.pop_front();
      check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(e.busy_cycles));
      check({tag, "_done_pulses"}, 32'(done_cnt), 32'(e.dones));
      check({tag, "_truth"}, get_truth(sel), e.truth);
      if (abort_x < 0) check({tag, "_x_final"}, 32'(get_x(sel)), 32'd31);
   endtask

   initial begin
      rst_n = 1'b1;
      drive(0, 1'b0, 1'b0);
      drive(1, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_x", 32'(x0), 32'd0);
      check("rst_busy", 32'(busy0), 32'd0);
      check("rst_done", 32'(done0), 32'd0);
      check("rst_truth", truth0, 32'd0);
      check("rst_pass", 32'(pass0), 32'd0);
      check("rst_err_cnt", 32'(ec0), 32'd0);
      check("rst_first_err", 32'(fe0), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      run(0, PARITY_TT, 64, -1, -1, "full");
`ifdef SWEEP_COMPARE_EN
      check("cmp_pass", 32'(pass0), 32'd1);
      check("cmp_pass_err_cnt", 32'(ec0), 32'd0);
      check("cmp_pass_first_err", 32'(fe0), 32'd0);
`else
      check("nocmp_pass", 32'(pass0), 32'd0);
      check("nocmp_err_cnt", 32'(ec0), 32'd0);
`endif

      run(0, PARITY_TT, 64, 20, -1, "ignstart");
      run(0, PARITY_TT & 32'h0000_03FF, 21, -1, 10, "abort");
      check("abort_upper_zero", 32'(truth0[31:10]), 32'd0);
      run(0, PARITY_TT, 64, -1, -1, "restart");

      run(1, PARITY_TT, 32, -1, -1, "settle1");
`ifdef SWEEP_COMPARE_EN
      check("cmp_fail_pass", 32'(pass1), 32'd0);
      check("cmp_fail_err_cnt", 32'(ec1), 32'd1);
      check("cmp_fail_first_err", 32'(fe1), 32'd1);
`else
      check("nocmp_first_err", 32'(fe1), 32'd0);
`endif

      // Asynchronous reset in the middle of a sweep
      @(posedge clk); #1 start0 = 1'b1;
      @(posedge clk); #1 start0 = 1'b0;
      repeat (30) @(negedge clk);
      check("mid_busy_before_rst", 32'(busy0), 32'd1);
      rst_n = 1'b0;
      #2;
      check("midrst_x", 32'(x0), 32'd0);
      check("midrst_busy", 32'(busy0), 32'd0);
      check("midrst_truth", truth0, 32'd0);
      check("midrst_truth1", truth1, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check("post_rst_busy", 32'(busy0), 32'd0);
      check("post_rst_done", 32'(done0), 32'd0);
      check("post_rst_x", 32'(x0), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
